bytes_to_bridge: RTL
====================

Name: bytes_to_bridge

Overview:
- Read-side counterpart of the bridge byte-write path.
- Accepts APF bridge read requests in the clk_74a domain, decoded by a fixed address window.
- Fetches the four bytes of the addressed 32-bit word from a byte-wide memory port with fixed read latency, then assembles them big-endian.
- Returns the word on bridge_rd_data with a one-cycle ready pulse; used for high-score/NVRAM readback to the host.

Parameters:
- fixed_bits, 32'h00000000, required value of the address bits selected by fixed_mask.
- fixed_mask, 32'hfffc0000, address bits that must equal fixed_bits for the block to respond.
- read_cycles, 2, clocks from mem_rd pulse to mem_rd_data valid; legal range 1..15.

Ports:
- clk_74a  input  1  bridge clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bridge_addr  input  32  bridge byte address.
- bridge_rd  input  1  single-cycle read strobe.
- bridge_rd_data  output  32  assembled word; held until the next completion.
- bridge_rd_ready  output  1  one-cycle pulse when bridge_rd_data is updated.
- selected  output  1  combinational: (bridge_addr & fixed_mask) == fixed_bits.
- mem_address  output  32  byte address presented with mem_rd.
- mem_rd  output  1  one-cycle read strobe to the byte memory.
- mem_rd_data  input  8  byte returned read_cycles clocks after mem_rd.
- busy  output  1  high from request accept until ready pulse.
- cache_invalidate  input  1  clears the cached word; ignored when the optional feature is compiled out.

Behaviour:
- Reset, synchronous: next state IDLE; bridge_rd_data=0, bridge_rd_ready=0, mem_rd=0, mem_address=0, busy=0; cache invalid.
- Accept condition: in IDLE, bridge_rd=1 and selected=1.
- On accept, latch base = bridge_addr & ~32'h3. Unaligned low bits are ignored.
- States:
  - IDLE -> ISSUE on accept.
  - ISSUE: drive mem_rd=1 and mem_address = base + byte_idx. Go to WAIT with wait counter = read_cycles.
  - WAIT: decrement the counter. When it reaches 0, capture mem_rd_data into lane byte_idx.
    - If byte_idx < 3: increment byte_idx, go to ISSUE.
    - Else go to DONE.
  - DONE: bridge_rd_data = assembled word; bridge_rd_ready=1 for this cycle only; go to IDLE.
- Lane mapping: byte at base+0 goes to bits 31:24, base+1 to 23:16, base+2 to 15:8, base+3 to 7:0.
- Timing, with accept at cycle 0 and R = read_cycles:
  - byte k mem_rd at cycle 1 + k(R+1);
  - capture at cycle 1 + k(R+1) + R;
  - bridge_rd_ready at cycle 4(R+1) + 1. For R=2 that is cycle 13.
- bridge_rd_data changes only in DONE; partial captures are held in an internal register.
- bridge_rd while busy=1: dropped. No queueing; the in-flight read is unaffected.
- bridge_rd with selected=0: ignored. No mem_rd is issued.
- mem_address increments without carry beyond base+3; no wrap handling is needed because base is aligned.
- Reset asserted mid-read: abort on the next edge. No ready pulse; outputs return to reset values.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: BYTES_TO_BRIDGE_CACHE_EN.
- Defined:
  - A single-entry cache holds the last completed word and its base address.
  - An accept whose base matches a valid entry skips ISSUE/WAIT: DONE is entered at cycle 1 and ready pulses at cycle 1, with no mem_rd.
  - Every memory completion refills the entry.
  - cache_invalidate=1 clears the valid bit on the next edge. If it coincides with a completion, invalidate wins and the entry ends invalid.
- Undefined: every accept reads memory; cache_invalidate is unused.

Test Plan:
- Aligned read, R=2, memory bytes 0x12,0x34,0x56,0x78 at 0x100..0x103; bridge_rd addr 0x100 -> mem_rd at cycles 1,4,7,10 with addresses 0x100..0x103; ready at cycle 13; data 32'h12345678.
- Unaligned addr 0x103, same memory -> mem_address sequence 0x100..0x103; data 32'h12345678.
- Out-of-window addr 0x00040000 -> selected=0; no mem_rd; no ready; bridge_rd_data keeps its prior value.
- Second bridge_rd at cycle 5 during a read of 0x100 -> ignored; exactly one ready pulse at cycle 13; 4 mem_rd total.
- Reset at cycle 6 -> mem_rd=0, busy=0, bridge_rd_data=0 from cycle 7; no ready pulse; a new read of 0x100 afterwards completes normally.
- With BYTES_TO_BRIDGE_CACHE_EN:
  - Read 0x100 twice -> second ready at cycle 1 with no mem_rd.
  - Pulse cache_invalidate, then read again -> full 13-cycle read.

Source files
------------

// File: rtl/bytes_to_bridge.sv
// Bridge read path: fetches four bytes of an aligned word from a byte memory and returns them big-endian.
// Optional single-entry word cache enabled by defining BYTES_TO_BRIDGE_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for a selected bridge read
// ISSUE | mem_rd strobe visible for byte byte_idx
// WAIT  | counting down memory read latency, capture on terminal count
// DONE  | bridge_rd_data updated, bridge_rd_ready pulse visible
module bytes_to_bridge #(
    parameter logic [31:0] fixed_bits  = 32'h00000000,
    parameter logic [31:0] fixed_mask  = 32'hfffc0000,
    parameter int          read_cycles = 2
) (
    input  logic        clk_74a,
    input  logic        reset,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic        bridge_rd_ready,
    output logic        selected,
    output logic [31:0] mem_address,
    output logic        mem_rd,
    input  logic [7:0]  mem_rd_data,
    output logic        busy,
    input  logic        cache_invalidate
);

    localparam logic [3:0] wait_load = 4'(read_cycles);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    logic [29:0] base_word;
    logic [1:0]  byte_idx;
    logic [3:0]  wait_cnt;
    logic [31:0] word_acc;
    logic        accept;
    logic        cache_hit;

    assign selected = (bridge_addr & fixed_mask) == fixed_bits;
    assign accept   = (state == IDLE) && bridge_rd && selected;
    assign busy     = (state != IDLE);

`ifdef BYTES_TO_BRIDGE_CACHE_EN
    logic        cache_valid;
    logic [29:0] cache_base;
    logic [31:0] cache_data;

    assign cache_hit = cache_valid && (cache_base == bridge_addr[31:2]);
`else
    logic unused_cache_invalidate;

    assign cache_hit               = 1'b0;
    assign unused_cache_invalidate = cache_invalidate;
`endif

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state           <= IDLE;
            base_word       <= '0;
            byte_idx        <= '0;
            wait_cnt        <= '0;
            word_acc        <= '0;
            bridge_rd_data  <= '0;
            bridge_rd_ready <= 1'b0;
            mem_rd          <= 1'b0;
            mem_address     <= '0;
`ifdef BYTES_TO_BRIDGE_CACHE_EN
            cache_valid     <= 1'b0;
            cache_base      <= '0;
            cache_data      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_word <= bridge_addr[31:2];
                        byte_idx  <= 2'd0;
                        if (cache_hit) begin
`ifdef BYTES_TO_BRIDGE_CACHE_EN
                            bridge_rd_data <= cache_data;
`endif
                            bridge_rd_ready <= 1'b1;
                            state           <= DONE;
                        end else begin
                            mem_rd      <= 1'b1;
                            mem_address <= {bridge_addr[31:2], 2'b00};
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_rd   <= 1'b0;
                    wait_cnt <= wait_load;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    // Counter hits zero on this edge: the byte is valid now.
                    if (wait_cnt == 4'd1) begin
                        if (byte_idx == 2'd3) begin
                            bridge_rd_data  <= {word_acc[31:8], mem_rd_data};
                            bridge_rd_ready <= 1'b1;
                            state           <= DONE;
`ifdef BYTES_TO_BRIDGE_CACHE_EN
                            cache_valid <= 1'b1;
                            cache_base  <= base_word;
                            cache_data  <= {word_acc[31:8], mem_rd_data};
`endif
                        end else begin
                            case (byte_idx)
                                2'd0:    word_acc[31:24] <= mem_rd_data;
                                2'd1:    word_acc[23:16] <= mem_rd_data;
                                default: word_acc[15:8]  <= mem_rd_data;
                            endcase
                            byte_idx    <= byte_idx + 2'd1;
                            mem_rd      <= 1'b1;
                            mem_address <= {base_word, byte_idx + 2'd1};
                            state       <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    bridge_rd_ready <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef BYTES_TO_BRIDGE_CACHE_EN
            // Invalidate overrides a refill landing on the same edge.
            if (cache_invalidate) cache_valid <= 1'b0;
`endif
        end
    end

endmodule
